// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift sequencer.
//   Mode encodings : operation selected for a shift sequence (3 bits).
//   state_e        : sequencer FSM states.
//   is_shift_mode  : true for the five defined shift operations; the
//                    reserved codes hold q (and carry) while cycles are counted.
package shift_pkg;

  localparam logic [2:0] MODE_SHL = 3'b000;  // ser_r into LSB, MSB out
  localparam logic [2:0] MODE_SHR = 3'b001;  // ser_l into MSB, LSB out
  localparam logic [2:0] MODE_ROL = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ASR = 3'b100;  // MSB replicated, LSB out

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-step combinational shifter.
//   vec      in  : current register contents
//   mode     in  : shift operation (see shift_pkg)
//   ser_l    in  : serial bit entering the MSB on SHR
//   ser_r    in  : serial bit entering the LSB on SHL
//   vec_nxt  out : contents after one shift
//   out_bit  out : bit shifted out (0 for reserved modes)
module shift_step
  import shift_pkg::*;
#(
  parameter int bits = 8
) (
  input  logic [bits-1:0] vec,
  input  logic [2:0]      mode,
  input  logic            ser_l,
  input  logic            ser_r,
  output logic [bits-1:0] vec_nxt,
  output logic            out_bit
);

  always_comb begin
    vec_nxt = vec;
    out_bit = 1'b0;
    case (mode)
      MODE_SHL: begin
        vec_nxt = {vec[bits-2:0], ser_r};
        out_bit = vec[bits-1];
      end
      MODE_SHR: begin
        vec_nxt = {ser_l, vec[bits-1:1]};
        out_bit = vec[0];
      end
      MODE_ROL: begin
        vec_nxt = {vec[bits-2:0], vec[bits-1]};
        out_bit = vec[bits-1];
      end
      MODE_ROR: begin
        vec_nxt = {vec[0], vec[bits-1:1]};
        out_bit = vec[0];
      end
      MODE_ASR: begin
        vec_nxt = {vec[bits-1], vec[bits-1:1]};
        out_bit = vec[0];
      end
      default: begin
        vec_nxt = vec;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_seq.sv
// Universal shift register with a multi-cycle shift sequencer.
//   clk    in  : clock, rising edge
//   rst    in  : synchronous active-low reset
//   d_in   in  : parallel load data
//   load   in  : parallel load (IDLE/DONE only, wins over start)
//   start  in  : begin a sequence (IDLE/DONE only)
//   mode   in  : shift operation, sampled with start
//   count  in  : number of shifts, sampled with start, clamped to bits
//   ser_l  in  : serial input to MSB on SHR, sampled on every shift edge
//   ser_r  in  : serial input to LSB on SHL, sampled on every shift edge
//   q      out : register contents
//   carry  out : last bit shifted out
//   busy   out : sequence in progress
//   done   out : one-cycle completion pulse
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting; load/start accepted
// ST_SHIFT | one shift per edge until the counter expires
// ST_DONE  | completion cycle; load/start still accepted
module univ_shift_seq
  import shift_pkg::*;
#(
  parameter int bits = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [bits-1:0]             d_in,
  input  logic                        load,
  input  logic                        start,
  input  logic [2:0]                  mode,
  input  logic [$clog2(bits+0)+1-1:0] count,
  input  logic                        ser_l,
  input  logic                        ser_r,
  output logic [bits-1:0]             q,
  output logic                        carry,
  output logic                        busy,
  output logic                        done
);

  localparam int CNT_W = $clog2(bits) + 1;
  localparam logic [CNT_W-1:0] BITS_C = CNT_W'(bits);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_eff;
  logic [2:0]       mode_q;
  logic [bits-1:0]  step_vec;
  logic             step_out;
  logic             accept;

  assign cnt_eff = (count > BITS_C) ? BITS_C : count;
  assign accept  = (state_q != ST_SHIFT) && start && !load;

  shift_step #(.bits(bits)) u_step (
    .vec     (q),
    .mode    (mode_q),
    .ser_l   (ser_l),
    .ser_r   (ser_r),
    .vec_nxt (step_vec),
    .out_bit (step_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done    = (state_q == ST_DONE);
        state_d = ST_IDLE;
        if (accept) state_d = (cnt_eff == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q      <= '0;
      carry  <= 1'b0;
      cnt_q  <= '0;
      mode_q <= MODE_SHL;
    end else if (state_q == ST_SHIFT) begin
      q     <= step_vec;
      cnt_q <= cnt_q - CNT_W'(1);
      // reserved modes leave carry alone along with q
      if (is_shift_mode(mode_q)) carry <= step_out;
    end else if (load) begin
      q <= d_in;
    end else if (start) begin
      mode_q <= mode;
      cnt_q  <= cnt_eff;
    end
  end

endmodule

// File: tb/tb_univ_shift_seq.sv
module tb_univ_shift_seq;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d_in = '0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mode = '0;
  logic [3:0] count = '0;
  logic       ser_l = 1'b0;
  logic       ser_r = 1'b0;
  logic [7:0] q;
  logic       carry, busy, done;

  int tests = 0;
  int fails = 0;

  univ_shift_seq #(.bits(8)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .load(load), .start(start),
    .mode(mode), .count(count), .ser_l(ser_l), .ser_r(ser_r),
    .q(q), .carry(carry), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    d_in = v; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] m, input logic [3:0] c);
    mode = m; count = c; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // reset
    #1;
    rst = 1'b0;
    step();
    chk("rst_q", q, 8'h00);
    chk("rst_carry", carry, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b1;

    // parallel load
    do_load(8'd25);
    chk("load_q", q, 8'b00011001);
    chk("load_busy", busy, 1'b0);
    chk("load_done", done, 1'b0);

    // SHL by 1, ser_r=1
    do_load(8'h81);
    ser_r = 1'b1;
    do_start(MODE_SHL, 4'd1);
    chk("shl_busy", busy, 1'b1);
    chk("shl_done0", done, 1'b0);
    step();
    chk("shl_q", q, 8'h03);
    chk("shl_carry", carry, 1'b1);
    chk("shl_busy_end", busy, 1'b0);
    chk("shl_done", done, 1'b1);
    step();
    chk("shl_done_once", done, 1'b0);

    // ROR by 4 with an ignored mid-sequence load
    do_load(8'h96);
    do_start(MODE_ROR, 4'd4);
    for (int i = 0; i < 4; i++) begin
      chk("ror_busy", busy, 1'b1);
      if (i == 1) begin d_in = 8'h00; load = 1'b1; end
      step();
      load = 1'b0;
    end
    chk("ror_q", q, 8'h69);
    chk("ror_carry", carry, 1'b0);
    chk("ror_busy_end", busy, 1'b0);
    chk("ror_done", done, 1'b1);
    step();

    // ASR by 3, then back-to-back SHL from DONE
    do_load(8'h80);
    do_start(MODE_ASR, 4'd3);
    step(); step(); step();
    chk("asr_q", q, 8'hF0);
    chk("asr_carry", carry, 1'b0);
    chk("asr_done", done, 1'b1);
    ser_r = 1'b0;
    do_start(MODE_SHL, 4'd1);
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_done0", done, 1'b0);
    step();
    chk("b2b_q", q, 8'hE0);
    chk("b2b_carry", carry, 1'b1);
    chk("b2b_done", done, 1'b1);
    step();

    // SHR with count 12 saturates to 8
    do_load(8'hFF);
    ser_l = 1'b0;
    do_start(MODE_SHR, 4'd12);
    for (int i = 0; i < 8; i++) begin
      chk("shr_busy", busy, 1'b1);
      step();
    end
    chk("shr_q", q, 8'h00);
    chk("shr_carry", carry, 1'b1);
    chk("shr_busy_end", busy, 1'b0);
    chk("shr_done", done, 1'b1);
    step();

    // count=0: done pulse only
    do_load(8'h5A);
    do_start(MODE_SHL, 4'd0);
    chk("c0_busy", busy, 1'b0);
    chk("c0_done", done, 1'b1);
    chk("c0_q", q, 8'h5A);
    chk("c0_carry", carry, 1'b1);
    step();
    chk("c0_done_once", done, 1'b0);

    // ROL by 2
    do_load(8'hA5);
    do_start(MODE_ROL, 4'd2);
    step(); step();
    chk("rol_q", q, 8'h96);
    chk("rol_carry", carry, 1'b0);
    chk("rol_done", done, 1'b1);
    step();

    // reserved mode: counts cycles, q and carry held
    do_start(3'b110, 4'd2);
    chk("rsv_busy", busy, 1'b1);
    step();
    chk("rsv_busy2", busy, 1'b1);
    step();
    chk("rsv_q", q, 8'h96);
    chk("rsv_carry", carry, 1'b0);
    chk("rsv_done", done, 1'b1);
    step();

    // reset at the third shift edge of a 6-shift sequence
    do_load(8'hFF);
    do_start(MODE_SHL, 4'd6);
    step(); step();
    chk("abort_pre_q", q, 8'hFC);
    chk("abort_pre_carry", carry, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("abort_q", q, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_carry", carry, 1'b0);
    chk("abort_done", done, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_done", done, 1'b0);
      chk("abort_no_shift", q, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
